// File: rtl/load_unit_if.sv
// Data-memory read channel between the load unit (master) and memory (slave).
// The request is held until mem_ready; mem_rdata is valid in the same cycle as mem_ready.
interface load_unit_if #(
    parameter int DATA_WIDTH = 32
);
    logic [DATA_WIDTH-1:0] mem_addr;
    logic                  mem_read_en;
    logic                  mem_ready;
    logic [DATA_WIDTH-1:0] mem_rdata;

    modport master (
        output mem_addr,
        output mem_read_en,
        input  mem_ready,
        input  mem_rdata
    );

    modport slave (
        input  mem_addr,
        input  mem_read_en,
        output mem_ready,
        output mem_rdata
    );
endinterface

// File: rtl/load_unit.sv
// Multi-cycle MIPS load datapath (lb/lh/lw/lbu/lhu) with a big-endian byte/half extractor.
// Optional macro LOAD_TIMEOUT_EN aborts a request after TIMEOUT cycles without mem_ready.
module load_unit #(
    parameter int DATA_WIDTH = 32
`ifdef LOAD_TIMEOUT_EN
    ,
    parameter int TIMEOUT    = 64
`endif
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [31:0]           instruction,
    input  logic [DATA_WIDTH-1:0] Read_data1,
    output logic                  busy,
    load_unit_if.master           mem,
    output logic [4:0]            reg_write_addr,
    output logic [DATA_WIDTH-1:0] reg_write_data,
    output logic                  reg_write_enable,
    output logic                  done,
    output logic                  error
);

    localparam logic [5:0] OP_LB  = 6'h20;
    localparam logic [5:0] OP_LH  = 6'h21;
    localparam logic [5:0] OP_LW  = 6'h23;
    localparam logic [5:0] OP_LBU = 6'h24;
    localparam logic [5:0] OP_LHU = 6'h25;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_ADDR = 3'd1,
        S_REQ  = 3'd2,
        S_WB   = 3'd3,
        S_ERR  = 3'd4
    } state_t;

    state_t                  state_r;
    state_t                  state_nxt_s;
    logic [5:0]              op_r;
    logic [4:0]              rt_r;
    logic [15:0]             imm_r;
    logic [DATA_WIDTH-1:0]   rs_r;
    logic [1:0]              lane_r;
    logic [DATA_WIDTH-1:0]   ea_s;
    logic                    op_ok_s;
    logic                    misaligned_s;
    logic                    tmo_hit_s;
    logic [7:0]              byte_s;
    logic [15:0]             half_s;
    logic [DATA_WIDTH-1:0]   load_data_s;

    logic                    busy_r;
    logic                    mem_read_en_r;
    logic [DATA_WIDTH-1:0]   mem_addr_r;
    logic [4:0]              reg_write_addr_r;
    logic [DATA_WIDTH-1:0]   reg_write_data_r;
    logic                    reg_write_enable_r;
    logic                    done_r;
    logic                    error_r;

    // The rs field is consumed upstream; only the value on Read_data1 matters here.
    logic unused_rs_field_s;
    assign unused_rs_field_s = ^instruction[25:21];

`ifdef LOAD_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] tmo_cnt_r;

    // Wait counter: zero outside REQ, so it restarts on every REQ entry.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tmo_cnt_r <= {TW{1'b0}};
        end else if (state_r != S_REQ) begin
            tmo_cnt_r <= {TW{1'b0}};
        end else begin
            tmo_cnt_r <= tmo_cnt_r + {{(TW-1){1'b0}}, 1'b1};
        end
    end
    assign tmo_hit_s = (tmo_cnt_r == TW'(TIMEOUT - 1));
`else
    assign tmo_hit_s = 1'b0;
`endif

    // Effective address, opcode legality and alignment check.
    always_comb begin
        ea_s         = rs_r + {{(DATA_WIDTH-16){imm_r[15]}}, imm_r};
        op_ok_s      = 1'b1;
        misaligned_s = 1'b0;
        case (op_r)
            OP_LB, OP_LBU: misaligned_s = 1'b0;
            OP_LH, OP_LHU: misaligned_s = ea_s[0];
            OP_LW:         misaligned_s = |ea_s[1:0];
            default:       op_ok_s      = 1'b0;
        endcase
    end

    // Big-endian lane select and sign/zero extension of the returned word.
    always_comb begin
        case (lane_r)
            2'd0:    byte_s = mem.mem_rdata[31:24];
            2'd1:    byte_s = mem.mem_rdata[23:16];
            2'd2:    byte_s = mem.mem_rdata[15:8];
            2'd3:    byte_s = mem.mem_rdata[7:0];
            default: byte_s = 8'h00;
        endcase
        if (lane_r[1]) begin
            half_s = mem.mem_rdata[15:0];
        end else begin
            half_s = mem.mem_rdata[31:16];
        end
        case (op_r)
            OP_LB:   load_data_s = {{(DATA_WIDTH-8){byte_s[7]}}, byte_s};
            OP_LBU:  load_data_s = {{(DATA_WIDTH-8){1'b0}}, byte_s};
            OP_LH:   load_data_s = {{(DATA_WIDTH-16){half_s[15]}}, half_s};
            OP_LHU:  load_data_s = {{(DATA_WIDTH-16){1'b0}}, half_s};
            default: load_data_s = mem.mem_rdata;
        endcase
    end

    // Next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (start) state_nxt_s = S_ADDR;
                else       state_nxt_s = S_IDLE;
            end
            S_ADDR: begin
                if (!op_ok_s || misaligned_s) state_nxt_s = S_ERR;
                else                          state_nxt_s = S_REQ;
            end
            S_REQ: begin
                if (mem.mem_ready)  state_nxt_s = S_WB;
                else if (tmo_hit_s) state_nxt_s = S_ERR;
                else                state_nxt_s = S_REQ;
            end
            S_WB:    state_nxt_s = S_IDLE;
            S_ERR:   state_nxt_s = S_IDLE;
            default: state_nxt_s = S_IDLE;
        endcase
    end

    // State register; control outputs are registered from the next state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r            <= S_IDLE;
            busy_r             <= 1'b0;
            mem_read_en_r      <= 1'b0;
            done_r             <= 1'b0;
            error_r            <= 1'b0;
            reg_write_enable_r <= 1'b0;
        end else begin
            state_r            <= state_nxt_s;
            busy_r             <= (state_nxt_s != S_IDLE);
            mem_read_en_r      <= (state_nxt_s == S_REQ);
            done_r             <= (state_nxt_s == S_WB) || (state_nxt_s == S_ERR);
            error_r            <= (state_nxt_s == S_ERR);
            reg_write_enable_r <= (state_nxt_s == S_WB) && (rt_r != 5'd0);
        end
    end

    // Operand capture, address register and write-back result.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            op_r             <= 6'd0;
            rt_r             <= 5'd0;
            imm_r            <= 16'd0;
            rs_r             <= {DATA_WIDTH{1'b0}};
            lane_r           <= 2'd0;
            mem_addr_r       <= {DATA_WIDTH{1'b0}};
            reg_write_addr_r <= 5'd0;
            reg_write_data_r <= {DATA_WIDTH{1'b0}};
        end else begin
            if ((state_r == S_IDLE) && start) begin
                op_r  <= instruction[31:26];
                rt_r  <= instruction[20:16];
                imm_r <= instruction[15:0];
                rs_r  <= Read_data1;
            end
            if (state_r == S_ADDR) begin
                lane_r     <= ea_s[1:0];
                mem_addr_r <= {ea_s[DATA_WIDTH-1:2], 2'b00};
            end
            if ((state_r == S_REQ) && (state_nxt_s == S_WB)) begin
                reg_write_addr_r <= rt_r;
                reg_write_data_r <= load_data_s;
            end
        end
    end

    assign busy             = busy_r;
    assign mem.mem_addr     = mem_addr_r;
    assign mem.mem_read_en  = mem_read_en_r;
    assign reg_write_addr   = reg_write_addr_r;
    assign reg_write_data   = reg_write_data_r;
    assign reg_write_enable = reg_write_enable_r;
    assign done             = done_r;
    assign error            = error_r;

endmodule
